result_serializer: RTL

- Downstream stage of the 20-bit root/division result engine. It consumes each one-cycle `in_valid`/`in_data` result pulse from that stage.
- Buffers the results in a small FIFO, then streams each one as MSB-first bytes on a valid/ready byte interface toward the chip output / UART packer.
- Decouples the engine's bursty single-cycle results from a back-pressured consumer. Reports dropped results on overflow.

---
 rtl/result_serializer_pkg.sv | 42 ++++
 rtl/result_serializer_sync_fifo.sv | 61 ++++++
 rtl/result_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/result_serializer_pkg.sv
// Shared types and helpers for the result serializer.
// Optional macro RESULT_SER_CHECKSUM_EN appends an XOR checksum byte to every frame.
package result_ser_pkg;

  localparam int unsigned DATA_W = 20;

`ifdef RESULT_SER_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 4;
`else
  localparam int unsigned FRAME_BYTES = 3;
`endif

  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  // Maps a byte index to its slice of the result word, MSB first.
  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] d,
                                          input logic [IDX_W-1:0]  idx);
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    b0 = {4'b0, d[19:16]};
    b1 = d[15:8];
    b2 = d[7:0];
    case (idx)
      2'd0:    byte_sel = b0;
      2'd1:    byte_sel = b1;
      2'd2:    byte_sel = b2;
`ifdef RESULT_SER_CHECKSUM_EN
      default: byte_sel = b0 ^ b1 ^ b2;
`else
      default: byte_sel = '0;
`endif
    endcase
  endfunction

endpackage

// File: rtl/result_serializer_sync_fifo.sv
// Synchronous FIFO with registered read data; push is accepted when full
// provided a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rdata  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_serializer.sv
// Buffers single-cycle results and streams each as an MSB-first byte frame
// on a valid/ready interface. Macro RESULT_SER_CHECKSUM_EN adds a checksum byte.
module result_serializer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import result_ser_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic [DATA_W-1:0] frame_q;
  logic [DATA_W-1:0] frame_d;
  logic              valid_d;
  logic [7:0]        data_d;
  logic              last_d;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign idx_inc = idx_q + IDX_W'(1);
  assign drop    = in_valid && fifo_full && !fifo_pop;

  // Next-state and next-output logic; output registers hold unless changed.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    valid_d  = out_valid;
    data_d   = out_data;
    last_d   = out_last;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // Read data was registered by the pop, so B0 comes straight from it.
        frame_d = fifo_rdata;
        data_d  = byte_sel(fifo_rdata, '0);
        last_d  = 1'b0;
        valid_d = 1'b1;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_valid && out_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = idx_inc;
            data_d = byte_sel(frame_q, idx_inc);
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, frame and output registers plus the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      frame_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
      overflow  <= overflow | drop;
    end
  end

endmodule
